// File: rtl/call_stack_unit.sv
// LIFO stack for stk instructions: top_data is combinational from registered state, pushes visible next cycle.
// No backpressure: a push when full or a pop when empty is dropped and latches a sticky error flag.
module call_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             stack_full,
  output logic             stack_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] sp, sp_nxt;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic             wr_en, ovf_evt, udf_evt;

  assign stack_full  = (sp == DEPTH_C);
  assign stack_empty = (sp == '0);
  assign count       = sp;
  assign rd_idx      = AW'(sp - ONE_C);
  // Never expose stale (unreset) storage while the stack is empty.
  assign top_data    = stack_empty ? '0 : mem[rd_idx];

  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_idx  = AW'(sp);
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (push_en && pop_en) begin
      wr_en = 1'b1;
      if (stack_empty) begin
        // Pop has nothing to consume, so this degenerates to a plain push.
        sp_nxt = sp + ONE_C;
      end else begin
        wr_idx = rd_idx;
      end
    end else if (push_en) begin
      if (stack_full) begin
        ovf_evt = 1'b1;
      end else begin
        wr_en  = 1'b1;
        sp_nxt = sp + ONE_C;
      end
    end else if (pop_en) begin
      if (stack_empty) begin
        udf_evt = 1'b1;
      end else begin
        sp_nxt = sp - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      // A fresh error in the same cycle as clear_err takes priority.
      overflow  <= ovf_evt | (overflow  & ~clear_err);
      underflow <= udf_evt | (underflow & ~clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: tb/tb_call_stack_unit.sv
// Self-checking bench for call_stack_unit: directed vector table, async-reset sequence, randomized run vs a queue model.
module tb_call_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             push_en, pop_en, clear_err;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top_data;
  logic             stack_full, stack_empty, overflow, underflow;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  call_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_en    (push_en),
    .pop_en     (pop_en),
    .push_data  (push_data),
    .top_data   (top_data),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_err  (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        push;
    bit        pop;
    bit        clr;
    bit [15:0] dat;
    int        cnt;
    bit [15:0] top;
    bit        full;
    bit        empty;
    bit        ovf;
    bit        udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit p, bit q, bit c, bit [15:0] d, int n, bit [15:0] t,
                              bit f, bit e, bit o, bit u);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.dat = d;
    v.cnt = n; v.top = t; v.full = f; v.empty = e; v.ovf = o; v.udf = u;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(string tag, int n, bit [15:0] t, bit f, bit e, bit o, bit u);
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".top"},   32'(top_data), 32'(t));
    chk({tag, ".full"},  32'(stack_full), 32'(f));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(e));
    chk({tag, ".ovf"},   32'(overflow), 32'(o));
    chk({tag, ".udf"},   32'(underflow), 32'(u));
  endtask

  task automatic drive(bit p, bit q, bit c, bit [15:0] d);
    @(negedge clk);
    push_en = p; pop_en = q; clear_err = c; push_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [15:0] mq[$];
  bit          m_ovf, m_udf;

  task automatic model_step(bit p, bit q, bit c, bit [15:0] d);
    bit eo, eu;
    eo = 1'b0; eu = 1'b0;
    if (p && q) begin
      if (mq.size() > 0) mq[mq.size()-1] = d;
      else mq.push_back(d);
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else eo = 1'b1;
    end else if (q) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else eu = 1'b1;
    end
    m_ovf = eo ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = eu ? 1'b1 : (c ? 1'b0 : m_udf);
  endtask

  function automatic bit [15:0] model_top();
    return (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [15:0] prev_top;
    rst_n = 1'b0; push_en = 0; pop_en = 0; clear_err = 0; push_data = '0;
    #12;
    chk_state("reset", 0, 16'h0000, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; each record lists expected state after the edge.
    tbl.push_back(mk(0,0,0,16'h0000, 0,16'h0000,0,1,0,0));
    tbl.push_back(mk(1,0,0,16'h1111, 1,16'h1111,0,0,0,0));
    tbl.push_back(mk(1,0,0,16'h2222, 2,16'h2222,0,0,0,0));
    tbl.push_back(mk(1,0,0,16'h3333, 3,16'h3333,0,0,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 2,16'h2222,0,0,0,0));
    tbl.push_back(mk(1,1,0,16'hBEEF, 2,16'hBEEF,0,0,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 1,16'h1111,0,0,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 0,16'h0000,0,1,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 0,16'h0000,0,1,0,1));
    tbl.push_back(mk(0,0,1,16'h0000, 0,16'h0000,0,1,0,0));
    tbl.push_back(mk(0,1,1,16'h0000, 0,16'h0000,0,1,0,1));
    tbl.push_back(mk(0,0,1,16'h0000, 0,16'h0000,0,1,0,0));
    tbl.push_back(mk(1,1,0,16'h5A5A, 1,16'h5A5A,0,0,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 0,16'h0000,0,1,0,0));
    for (int i = 1; i <= DEPTH; i++)
      tbl.push_back(mk(1,0,0,16'(i), i,16'(i),i==DEPTH,0,0,0));
    tbl.push_back(mk(1,0,0,16'hDEAD, 8,16'h0008,1,0,1,0));
    for (int i = DEPTH-1; i >= 0; i--)
      tbl.push_back(mk(0,1,0,16'h0000, i,16'(i),0,i==0,1,0));
    tbl.push_back(mk(1,0,1,16'h00AB, 1,16'h00AB,0,0,0,0));
    tbl.push_back(mk(0,1,0,16'h0000, 0,16'h0000,0,1,0,0));

    prev_top = 16'h0000;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].dat);
      chk($sformatf("v%0d.pre_top", i), 32'(top_data), 32'(prev_top));
      tick();
      chk_state($sformatf("v%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].full,
                tbl[i].empty, tbl[i].ovf, tbl[i].udf);
      prev_top = tbl[i].top;
    end

    // Async reset between edges with five entries held.
    for (int i = 0; i < 5; i++) begin
      drive(1,0,0,16'hC000 + 16'(i));
      tick();
    end
    drive(0,0,0,16'h0000);
    chk("arst.pre_count", 32'(count), 32'd5);
    rst_n = 1'b0;
    #1;
    chk_state("arst", 0, 16'h0000, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,0,16'h00AA);
    tick();
    chk_state("post_arst", 1, 16'h00AA, 0, 0, 0, 0);
    drive(0,1,0,16'h0000);
    tick();

    // Randomized run against the queue model, alternating push-heavy and pop-heavy phases.
    mq.delete(); m_ovf = 0; m_udf = 0;
    for (int c = 0; c < 2000; c++) begin
      bit p, q, cl;
      bit [15:0] d;
      int bias;
      bias = ((c / 100) % 2 == 0) ? 70 : 30;
      p  = ($urandom_range(0,99) < bias);
      q  = ($urandom_range(0,99) < (100 - bias));
      cl = ($urandom_range(0,15) == 0);
      d  = 16'($urandom);
      drive(p, q, cl, d);
      chk("rnd.pre_top", 32'(top_data), 32'(model_top()));
      model_step(p, q, cl, d);
      tick();
      chk_state("rnd", mq.size(), model_top(), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_udf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
